// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Posted-write buffer between the execute stage's data-memory port and the
//   data memory. Stores are accepted in one cycle into a circular FIFO and
//   retired to memory in the background. Loads own the memory port whenever
//   they need it; a load that hits a buffered store is either forwarded
//   (youngest match) or held off until the matching entries have drained.
//
//   Build option: define STORE_FWD_EN to build the store-to-load forwarding
//   mux. Without it, a load hitting a buffered store stalls.
//
// Parameters
//   DEPTH   entry count, power of two, >= 2
//   DATA_W  address and data width
//
// Ports
//   clk        core clock
//   rst        synchronous reset, active low
//   cpu_write  store request          cpu_read   load request
//   cpu_addr   load/store word addr   cpu_wdata  store data
//   cpu_rdata  load data to EXE       stall      core must hold request/PC
//   mem_write  memory write strobe    mem_read   memory read strobe
//   mem_addr   memory address         mem_wdata  memory write data
//   mem_rdata  memory read data       mem_ready  memory accepts/completes
//   empty      no buffered stores     count      buffered store count
// -----------------------------------------------------------------------------

// One buffer slot: holds {addr, data} and compares its address with the load.
module store_buffer_entry #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [DATA_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] cmp_addr,
  output logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              match
);
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (we) begin
      addr_d = wr_addr;
      data_d = wr_data;
    end
  end

  // Payload needs no reset: validity comes from head/count in the parent.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign addr  = addr_q;
  assign data  = data_q;
  assign match = (addr_q == cmp_addr);
endmodule

module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_write,
  input  logic                       cpu_read,
  input  logic [DATA_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       stall,
  output logic                       mem_write,
  output logic                       mem_read,
  output logic [DATA_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ready,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [DEPTH-1:0]             ent_we;
  logic [DEPTH-1:0]             ent_match;
  logic [DEPTH-1:0]             ent_vld;
  logic [DEPTH-1:0][DATA_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;

  logic full, load, hit, load_mem, push, pop;

  // Entries are valid iff they sit within count_q slots of the head, so
  // clearing count on reset invalidates everything at once.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] rel;
    assign rel        = PW'(i) - head_q;
    assign ent_vld[i] = (CW'(rel) < count_q);
    assign ent_we[i]  = push && (tail_q == PW'(i));

    store_buffer_entry #(.DATA_W(DATA_W)) u_ent (
      .clk      (clk),
      .we       (ent_we[i]),
      .wr_addr  (cpu_addr),
      .wr_data  (cpu_wdata),
      .cmp_addr (cpu_addr),
      .addr     (ent_addr[i]),
      .data     (ent_data[i]),
      .match    (ent_match[i])
    );
  end

  assign hit = |(ent_vld & ent_match);

`ifdef STORE_FWD_EN
  logic [DATA_W-1:0] fwd_data;
  logic [PW-1:0]     fwd_idx;

  // Walk oldest to youngest; the last match seen is the youngest store.
  always_comb begin
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && ent_match[fwd_idx]) fwd_data = ent_data[fwd_idx];
    end
  end
`endif

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    // Simultaneous read+write is illegal: the store wins, the read is dropped.
    load     = cpu_read && !cpu_write;
    load_mem = load && !hit;
    push     = cpu_write && !full;

    mem_read  = load_mem;
    mem_write = !load_mem && (count_q != '0);
    mem_addr  = '0;
    mem_wdata = '0;
    if (load_mem) begin
      mem_addr = cpu_addr;
    end else if (mem_write) begin
      mem_addr  = ent_addr[head_q];
      mem_wdata = ent_data[head_q];
    end
    pop = mem_write && mem_ready;

    cpu_rdata = '0;
    stall     = 1'b0;
    if (cpu_write) begin
      // Full is judged on the registered count, even if a pop happens now.
      stall = full;
    end else if (load_mem) begin
      cpu_rdata = mem_rdata;
      stall     = !mem_ready;
    end else if (load) begin
`ifdef STORE_FWD_EN
      cpu_rdata = fwd_data;
`else
      // Hold the load until the matching stores have drained.
      stall     = 1'b1;
`endif
    end

    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
endmodule
